// File: rtl/decode_pkg.sv
// Shared types and encodings for the x86-64 byte-serial instruction decoder.
package decode_pkg;

   localparam int MAX_LEN = 15;

   // Info-word field positions (each operand/size field is 2 bits, grp is 5).
   localparam int OP1_LSB = 19;
   localparam int OP2_LSB = 17;
   localparam int SZ1_LSB = 15;
   localparam int SZ2_LSB = 13;
   localparam int GRP_LSB = 0;

   localparam logic [1:0] OPT_NONE  = 2'b00;
   localparam logic [1:0] OPT_REG   = 2'b01;
   localparam logic [1:0] OPT_MODRM = 2'b10;
   localparam logic [1:0] OPT_IMM   = 2'b11;

   localparam logic [1:0] SZ_8  = 2'b00;
   localparam logic [1:0] SZ_16 = 2'b01;
   localparam logic [1:0] SZ_32 = 2'b10;
   localparam logic [1:0] SZ_64 = 2'b11;

   localparam logic [1:0] MOD_IND = 2'b00;
   localparam logic [1:0] MOD_D8  = 2'b01;
   localparam logic [1:0] MOD_D32 = 2'b10;
   localparam logic [1:0] MOD_REG = 2'b11;
   localparam logic [2:0] RM_SIB    = 3'b100;
   localparam logic [2:0] RM_DISP32 = 3'b101;
   localparam logic [2:0] BASE_NONE = 3'b101;

   localparam logic [7:0] PFX_OPSZ  = 8'h66;
   localparam logic [7:0] PFX_ADSZ  = 8'h67;
   localparam logic [7:0] PFX_LOCK  = 8'hF0;
   localparam logic [7:0] PFX_REPNE = 8'hF2;
   localparam logic [7:0] PFX_REP   = 8'hF3;
   localparam logic [7:0] PFX_CS    = 8'h2E;
   localparam logic [7:0] PFX_SS    = 8'h36;
   localparam logic [7:0] PFX_DS    = 8'h3E;
   localparam logic [7:0] PFX_ES    = 8'h26;
   localparam logic [7:0] PFX_FS    = 8'h64;
   localparam logic [7:0] PFX_GS    = 8'h65;
   localparam logic [7:0] ESC_0F    = 8'h0F;
   localparam logic [7:0] ESC_38    = 8'h38;
   localparam logic [7:0] ESC_3A    = 8'h3A;

   localparam logic [2:0] SEG_NONE = 3'd0;
   localparam logic [2:0] SEG_CS   = 3'd1;
   localparam logic [2:0] SEG_SS   = 3'd2;
   localparam logic [2:0] SEG_DS   = 3'd3;
   localparam logic [2:0] SEG_ES   = 3'd4;
   localparam logic [2:0] SEG_FS   = 3'd5;
   localparam logic [2:0] SEG_GS   = 3'd6;

   typedef enum logic [2:0] {
      S_PFX, S_OPC2, S_MODRM, S_SIB, S_DISP, S_IMM, S_DONE
   } state_t;

   typedef struct packed {
      logic        opsz;
      logic        adsz;
      logic        lock;
      logic        rep;
      logic        repne;
      logic [2:0]  seg;
      logic [7:0]  rex;
      logic        map;
      logic [7:0]  opcode;
      logic [7:0]  modrm;
      logic [7:0]  sib;
      logic [31:0] disp;
      logic [63:0] imm;
      logic [22:0] info;
      logic [3:0]  len;
      logic        err;
   } decoded_t;

   function automatic logic is_legacy_pfx(input logic [7:0] b);
      logic hit;
      case (b)
         PFX_OPSZ, PFX_ADSZ, PFX_LOCK, PFX_REPNE, PFX_REP,
         PFX_CS, PFX_SS, PFX_DS, PFX_ES, PFX_FS, PFX_GS: hit = 1'b1;
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

   function automatic logic has_modrm(input logic [22:0] info);
      return (info[OP1_LSB +: 2] == OPT_MODRM) || (info[OP2_LSB +: 2] == OPT_MODRM) ||
             (info[GRP_LSB +: 5] != 5'd0);
   endfunction

   function automatic logic [3:0] imm_bytes(input logic [22:0] info, input logic opsz);
      logic       present;
      logic [1:0] sz;
      logic [3:0] n;
      present = 1'b1;
      sz      = SZ_8;
      if (info[OP1_LSB +: 2] == OPT_IMM)      sz = info[SZ1_LSB +: 2];
      else if (info[OP2_LSB +: 2] == OPT_IMM) sz = info[SZ2_LSB +: 2];
      else                                    present = 1'b0;
      case (sz)
         SZ_8:    n = 4'd1;
         SZ_16:   n = 4'd2;
         SZ_32:   n = opsz ? 4'd2 : 4'd4;
         default: n = 4'd8;
      endcase
      return present ? n : 4'd0;
   endfunction

endpackage

// File: rtl/modrm_size_calc.sv
// Derives SIB presence and displacement width from ModRM (and SIB once it has arrived).
module modrm_size_calc
   import decode_pkg::*;
(
   input  logic [7:0] modrm_i,
   input  logic [7:0] sib_i,
   input  logic       sib_present_i,
   output logic       need_sib_o,
   output logic [2:0] disp_bytes_o
);

   logic [1:0] mod_f;
   logic [2:0] rm_f;
   logic       sib_unused;

   assign mod_f      = modrm_i[7:6];
   assign rm_f       = modrm_i[2:0];
   assign sib_unused = ^sib_i[7:3];
   assign need_sib_o = !sib_present_i && (mod_f != MOD_REG) && (rm_f == RM_SIB);

   always_comb begin
      disp_bytes_o = 3'd0;
      if (mod_f == MOD_D8) begin
         disp_bytes_o = 3'd1;
      end else if (mod_f == MOD_D32) begin
         disp_bytes_o = 3'd4;
      end else if (mod_f == MOD_IND) begin
         if (sib_present_i ? (sib_i[2:0] == BASE_NONE) : (rm_f == RM_DISP32))
            disp_bytes_o = 3'd4;
      end
   end

endmodule

// File: rtl/inst_byte_decoder.sv
// Byte-serial x86-64 length/field decoder: one byte in per cycle, one record out per instruction.
//   S_PFX   | legacy/REX prefixes, 0F escape, or one-byte-map opcode
//   S_OPC2  | opcode byte of the 0F map
//   S_MODRM | ModRM byte
//   S_SIB   | SIB byte
//   S_DISP  | displacement bytes, little-endian
//   S_IMM   | immediate bytes, little-endian
//   S_DONE  | record held until consumer takes it
module inst_byte_decoder
   import decode_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_byte,
   output logic        info_map,
   output logic [7:0]  info_opc,
   input  logic [22:0] info_word,
   output logic        out_valid,
   input  logic        out_ready,
   output decoded_t    out_rec
);

   state_t     state_q, state_d;
   decoded_t   rec_q, rec_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] disp_sz_q, disp_sz_d;
   logic [3:0] imm_sz_q, imm_sz_d;

   logic       accept;
   logic       take_opc;
   logic       need_sib;
   logic [2:0] msc_disp;
   logic [3:0] opc_imm_sz;
   state_t     after_addr;

   assign in_ready   = (state_q != S_DONE) && reset_n;
   assign accept     = in_valid && in_ready;
   assign info_map   = (state_q == S_OPC2);
   assign info_opc   = in_byte;
   assign out_valid  = (state_q == S_DONE);
   assign out_rec    = rec_q;
   assign opc_imm_sz = imm_bytes(info_word, rec_q.opsz);
   assign after_addr = (imm_sz_q != 4'd0) ? S_IMM : S_DONE;

   modrm_size_calc u_msc (
      .modrm_i       ((state_q == S_MODRM) ? in_byte : rec_q.modrm),
      .sib_i         (in_byte),
      .sib_present_i (state_q == S_SIB),
      .need_sib_o    (need_sib),
      .disp_bytes_o  (msc_disp)
   );

   always_comb begin
      state_d   = state_q;
      rec_d     = rec_q;
      cnt_d     = cnt_q;
      disp_sz_d = disp_sz_q;
      imm_sz_d  = imm_sz_q;
      take_opc  = 1'b0;

      if (state_q == S_DONE) begin
         if (out_ready) begin
            state_d   = S_PFX;
            rec_d     = '0;
            cnt_d     = '0;
            disp_sz_d = '0;
            imm_sz_d  = '0;
         end
      end else if (accept) begin
         rec_d.len = rec_q.len + 4'd1;
         if (rec_q.len == 4'(MAX_LEN)) begin
            // Byte beyond the architectural limit is dropped, not recorded.
            rec_d.len = 4'(MAX_LEN);
            rec_d.err = 1'b1;
            state_d   = S_DONE;
         end else begin
            unique case (state_q)
               S_PFX: begin
                  if (is_legacy_pfx(in_byte)) begin
                     rec_d.rex = '0;
                     case (in_byte)
                        PFX_OPSZ:  rec_d.opsz  = 1'b1;
                        PFX_ADSZ:  rec_d.adsz  = 1'b1;
                        PFX_LOCK:  rec_d.lock  = 1'b1;
                        PFX_REP:   rec_d.rep   = 1'b1;
                        PFX_REPNE: rec_d.repne = 1'b1;
                        PFX_CS:    rec_d.seg   = SEG_CS;
                        PFX_SS:    rec_d.seg   = SEG_SS;
                        PFX_DS:    rec_d.seg   = SEG_DS;
                        PFX_ES:    rec_d.seg   = SEG_ES;
                        PFX_FS:    rec_d.seg   = SEG_FS;
                        default:   rec_d.seg   = SEG_GS;
                     endcase
                  end else if (in_byte[7:4] == 4'h4) begin
                     rec_d.rex = in_byte;
                  end else if (in_byte == ESC_0F) begin
                     state_d = S_OPC2;
                  end else begin
                     take_opc = 1'b1;
                  end
               end
               S_OPC2: begin
                  if (in_byte == ESC_38 || in_byte == ESC_3A) begin
                     rec_d.err = 1'b1;
                     state_d   = S_DONE;
                  end else begin
                     take_opc = 1'b1;
                  end
               end
               S_MODRM: begin
                  rec_d.modrm = in_byte;
                  disp_sz_d   = msc_disp;
                  if (need_sib)              state_d = S_SIB;
                  else if (msc_disp != 3'd0) state_d = S_DISP;
                  else                       state_d = after_addr;
               end
               S_SIB: begin
                  rec_d.sib = in_byte;
                  disp_sz_d = msc_disp;
                  state_d   = (msc_disp != 3'd0) ? S_DISP : after_addr;
               end
               S_DISP: begin
                  if (disp_sz_q == 3'd1) rec_d.disp = {{24{in_byte[7]}}, in_byte};
                  else                   rec_d.disp[{cnt_q[1:0], 3'b000} +: 8] = in_byte;
                  if ((cnt_q + 3'd1) == disp_sz_q) begin
                     cnt_d   = '0;
                     state_d = after_addr;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
               S_IMM: begin
                  rec_d.imm[{cnt_q, 3'b000} +: 8] = in_byte;
                  if (({1'b0, cnt_q} + 4'd1) == imm_sz_q) begin
                     cnt_d   = '0;
                     state_d = S_DONE;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
               default: ;
            endcase
         end
      end

      if (take_opc) begin
         rec_d.map    = (state_q == S_OPC2);
         rec_d.opcode = in_byte;
         rec_d.info   = info_word;
         imm_sz_d     = opc_imm_sz;
         if (has_modrm(info_word))     state_d = S_MODRM;
         else if (opc_imm_sz != 4'd0)  state_d = S_IMM;
         else                          state_d = S_DONE;
      end

      if (flush) begin
         state_d   = S_PFX;
         rec_d     = '0;
         cnt_d     = '0;
         disp_sz_d = '0;
         imm_sz_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_PFX;
         rec_q     <= '0;
         cnt_q     <= '0;
         disp_sz_q <= '0;
         imm_sz_q  <= '0;
      end else begin
         state_q   <= state_d;
         rec_q     <= rec_d;
         cnt_q     <= cnt_d;
         disp_sz_q <= disp_sz_d;
         imm_sz_q  <= imm_sz_d;
      end
   end

endmodule

// File: tb/tb_inst_byte_decoder.sv
// Directed bench for inst_byte_decoder; inputs change and outputs are sampled on negedge.
module tb_inst_byte_decoder;
   import decode_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n, flush, in_valid, in_ready, info_map, out_valid, out_ready;
   logic [7:0]  in_byte, info_opc;
   logic [22:0] info_word;
   decoded_t    out_rec;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  seq [16];
   int          seq_n;
   decoded_t    exp;

   always #5 clk = ~clk;

   inst_byte_decoder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_byte   (in_byte),
      .info_map  (info_map),
      .info_opc  (info_opc),
      .info_word (info_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_rec   (out_rec)
   );

   function automatic logic [22:0] mk_info(input logic [1:0] op1, input logic [1:0] op2,
                                           input logic [1:0] sz1, input logic [1:0] sz2,
                                           input logic [4:0] grp);
      return {2'b00, op1, op2, sz1, sz2, 4'h0, 4'h0, grp};
   endfunction

   task automatic load(input logic [127:0] bytes, input int n);
      for (int i = 0; i < n; i++) seq[i] = bytes[8*(n-1-i) +: 8];
      seq_n = n;
   endtask

   task automatic feed_seq();
      for (int i = 0; i < seq_n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_byte  = seq[i];
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_byte  = 8'h00;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (out_rec !== '0) begin errors++; $display("FAIL reset_out_rec: got %h want 0", out_rec); end
      reset_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_rex_modrm();
      info_word = mk_info(2'b10, 2'b10, 2'b00, 2'b00, 5'd0);
      load(128'h4889D8, 3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_byte  = seq[i];
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL rex_modrm_early_valid byte%0d: got %b want 0", i, out_valid); end
      end
      @(negedge clk);
      in_valid = 1'b0;
      exp = '0; exp.rex = 8'h48; exp.opcode = 8'h89; exp.modrm = 8'hD8; exp.info = info_word; exp.len = 4'd3;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL rex_modrm_valid: got %b want 1", out_valid); end
      checks++;
      if (out_rec !== exp) begin errors++; $display("FAIL rex_modrm_rec: got %h want %h", out_rec, exp); end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         begin errors++; $display("FAIL rex_modrm_handoff: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_0f_map();
      info_word = mk_info(2'b11, 2'b00, 2'b10, 2'b00, 5'd0);
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = 8'h0F;
      #1;
      checks++;
      if (info_map !== 1'b0 || info_opc !== 8'h0F)
         begin errors++; $display("FAIL map0_lookup: got map=%b opc=%h want 0/0f", info_map, info_opc); end
      @(negedge clk);
      in_byte = 8'h84;
      #1;
      checks++;
      if (info_map !== 1'b1 || info_opc !== 8'h84)
         begin errors++; $display("FAIL map1_lookup: got map=%b opc=%h want 1/84", info_map, info_opc); end
      load(128'h10000000, 4);
      feed_seq();
      exp = '0; exp.map = 1'b1; exp.opcode = 8'h84; exp.imm = 64'h10; exp.info = info_word; exp.len = 4'd6;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL jcc_imm32: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();
   endtask

   task automatic test_sib_disp_imm();
      info_word = mk_info(2'b10, 2'b11, 2'b00, 2'b10, 5'd0);
      load(128'h66C74424083412, 7);
      feed_seq();
      exp = '0; exp.opsz = 1'b1; exp.opcode = 8'hC7; exp.modrm = 8'h44; exp.sib = 8'h24;
      exp.disp = 32'h8; exp.imm = 64'h1234; exp.info = info_word; exp.len = 4'd7;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL sib_disp8_imm16: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();
   endtask

   task automatic test_modrm_forms();
      info_word = mk_info(2'b10, 2'b10, 2'b00, 2'b00, 5'd0);
      load(128'h8B0578563412, 6);
      feed_seq();
      exp = '0; exp.opcode = 8'h8B; exp.modrm = 8'h05; exp.disp = 32'h12345678; exp.info = info_word; exp.len = 4'd6;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL disp32_rip: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();

      load(128'h8B45F0, 3);
      feed_seq();
      exp = '0; exp.opcode = 8'h8B; exp.modrm = 8'h45; exp.disp = 32'hFFFFFFF0; exp.info = info_word; exp.len = 4'd3;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL disp8_sext: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();

      load(128'h8B042544332211, 7);
      feed_seq();
      exp = '0; exp.opcode = 8'h8B; exp.modrm = 8'h04; exp.sib = 8'h25; exp.disp = 32'h11223344;
      exp.info = info_word; exp.len = 4'd7;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL sib_base101: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();

      info_word = mk_info(2'b00, 2'b00, 2'b00, 2'b00, 5'd1);
      load(128'hFEC0, 2);
      feed_seq();
      exp = '0; exp.opcode = 8'hFE; exp.modrm = 8'hC0; exp.info = info_word; exp.len = 4'd2;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL grp_modrm: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();

      info_word = mk_info(2'b01, 2'b11, 2'b00, 2'b11, 5'd0);
      load(128'h48B80102030405060708, 10);
      feed_seq();
      exp = '0; exp.rex = 8'h48; exp.opcode = 8'hB8; exp.imm = 64'h0807060504030201; exp.info = info_word; exp.len = 4'd10;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL imm64: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();
   endtask

   task automatic test_prefix_rules();
      info_word = '0;
      load(128'h48662E64F3F067F290, 9);
      feed_seq();
      exp = '0; exp.opsz = 1'b1; exp.adsz = 1'b1; exp.lock = 1'b1; exp.rep = 1'b1; exp.repne = 1'b1;
      exp.seg = 3'd5; exp.opcode = 8'h90; exp.len = 4'd9;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL all_prefixes: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();

      load(128'h664890, 3);
      feed_seq();
      exp = '0; exp.opsz = 1'b1; exp.rex = 8'h48; exp.opcode = 8'h90; exp.len = 4'd3;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL rex_after_legacy: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();
   endtask

   task automatic test_overflow();
      info_word = '0;
      load(128'h66666666666666666666666666666666, 16);
      feed_seq();
      exp = '0; exp.opsz = 1'b1; exp.len = 4'd15; exp.err = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL overflow_rec: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();
      load(128'h90, 1);
      feed_seq();
      exp = '0; exp.opcode = 8'h90; exp.len = 4'd1;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL overflow_next: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();
   endtask

   task automatic test_three_byte_map();
      info_word = '0;
      load(128'h0F38, 2);
      feed_seq();
      exp = '0; exp.len = 4'd2; exp.err = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL map_0f38_err: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();
   endtask

   task automatic test_stall();
      info_word = '0;
      load(128'h90, 1);
      feed_seq();
      exp = '0; exp.opcode = 8'h90; exp.len = 4'd1;
      in_valid = 1'b1;
      in_byte  = 8'hC3;
      for (int c = 1; c <= 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_rec !== exp || in_ready !== 1'b0)
            begin errors++; $display("FAIL stall_cycle%0d: got v=%b rdy=%b %h want v=1 rdy=0 %h", c, out_valid, in_ready, out_rec, exp); end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL stall_cycle6: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin errors++; $display("FAIL stall_cycle7: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
   endtask

   task automatic test_flush();
      info_word = '0;
      load(128'h480F, 2);
      feed_seq();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_rec !== '0)
         begin errors++; $display("FAIL flush_clear: got v=%b %h want v=0 0", out_valid, out_rec); end
      load(128'hC3, 1);
      feed_seq();
      exp = '0; exp.opcode = 8'hC3; exp.len = 4'd1;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL flush_next: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      flush     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      flush     = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_rec !== '0 || in_ready !== 1'b1)
         begin errors++; $display("FAIL flush_in_done: got v=%b rdy=%b %h want v=0 rdy=1 0", out_valid, in_ready, out_rec); end
   endtask

   task automatic test_reset_mid();
      info_word = '0;
      load(128'h480F, 2);
      feed_seq();
      reset_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready: got %b want 0", in_ready); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_rec !== '0)
         begin errors++; $display("FAIL reset_mid_clear: got v=%b %h want v=0 0", out_valid, out_rec); end
      reset_n = 1'b1;
      load(128'hC3, 1);
      feed_seq();
      exp = '0; exp.opcode = 8'hC3; exp.len = 4'd1;
      checks++;
      if (out_valid !== 1'b1 || out_rec !== exp)
         begin errors++; $display("FAIL reset_mid_next: got v=%b %h want v=1 %h", out_valid, out_rec, exp); end
      handshake();
   endtask

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_byte   = 8'h00;
      out_ready = 1'b0;
      info_word = '0;
      test_reset();
      test_rex_modrm();
      test_0f_map();
      test_sib_disp_imm();
      test_modrm_forms();
      test_prefix_rules();
      test_overflow();
      test_three_byte_map();
      test_stall();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
